mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between instruction fetch (IF) and the load/store stage (MEM) of the pipeline. Registers one transaction at a time toward memory, drives the variable-latency memory handshake, and returns read data with a one-cycle done pulse. Produces `if_stall` and `mem_stall`, which the pipeline control uses alongside the load-use hazard stall to freeze PC, IF/ID and the MEM stage.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_timeout_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 8;
  localparam int unsigned ARB_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM,
    DONE_IF,
    DONE_MEM
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Watchdog cycle counter for the arbiter; instantiated only when MEM_ARB_TIMEOUT_EN is defined.
module arb_timeout_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT-1 so expired stays asserted until the next clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, MEM has fixed priority.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = ARB_ADDR_W,
  parameter int unsigned DATA_W  = ARB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              if_stall,
  output logic              mem_stall
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  arb_state_e state;
  logic       busy;
  logic       tmo_expired;

  assign busy = (state == BUSY_IF) || (state == BUSY_MEM);

`ifdef MEM_ARB_TIMEOUT_EN
  arb_timeout_counter #(
    .LIMIT(TIMEOUT)
  ) u_timeout_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .enable (busy && !m_ready),
    .expired(tmo_expired)
  );

  // Sticky until reset so software can see that an access was abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (busy && !m_ready && tmo_expired) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        // MEM is the older instruction, so it wins a simultaneous request.
        IDLE: begin
          if (mem_req) begin
            state   <= BUSY_MEM;
            m_req   <= 1'b1;
            m_we    <= mem_we;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
          end else if (if_req) begin
            state  <= BUSY_IF;
            m_req  <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= if_addr;
          end
        end
        BUSY_IF: begin
          if (m_ready || tmo_expired) begin
            if_rdata <= m_ready ? m_rdata : '0;
            m_req    <= 1'b0;
            if_done  <= 1'b1;
            state    <= DONE_IF;
          end
        end
        BUSY_MEM: begin
          if (m_ready || tmo_expired) begin
            if (!m_we) begin
              mem_rdata <= m_ready ? m_rdata : '0;
            end
            m_req    <= 1'b0;
            mem_done <= 1'b1;
            state    <= DONE_MEM;
          end
        end
        DONE_IF, DONE_MEM: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory model, per-scenario tasks, summary line.
module tb_mem_port_arbiter;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
  } acc_t;

  typedef struct {
    logic       is_if;
    logic [7:0] rdata;
  } done_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       if_req;
  logic [7:0] if_addr;
  logic [7:0] if_rdata;
  logic       if_done;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_done;
  logic       m_req;
  logic       m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic       m_ready;
  logic       if_stall;
  logic       mem_stall;
`ifdef MEM_ARB_TIMEOUT_EN
  logic       timeout_err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [256];
  acc_t       acc_q[$];
  done_t      done_q[$];
  logic       model_on = 1'b0;
  int         mem_wait = 0;
  int         wcnt     = 0;
  logic       prev_m_req = 1'b0;
  logic       m_req_rise = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .if_stall (if_stall),
    .mem_stall(mem_stall)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  // One clock: sample just after the edge, run scoreboard and memory model, then return for driving.
  task automatic tick();
    acc_t  ea;
    done_t ed;
    @(posedge clk);
    #1;
    cyc++;
    m_req_rise = m_req && !prev_m_req;
    total++;
    if ((if_done && mem_done) || (m_req && (if_done || mem_done))) begin
      bad++;
      $display("FAIL excl_outputs: if_done=%b mem_done=%b m_req=%b want no overlap", if_done, mem_done, m_req);
    end
    if (model_on) begin
      if (m_req_rise) begin
        total++;
        if (acc_q.size() == 0) begin
          bad++;
          $display("FAIL acc_start: got access addr=%h with none expected", m_addr);
        end else begin
          ea = acc_q.pop_front();
          if (m_addr !== ea.addr || m_we !== ea.we || (ea.we && m_wdata !== ea.wdata)) begin
            bad++;
            $display("FAIL acc_start: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                     m_addr, m_we, m_wdata, ea.addr, ea.we, ea.wdata);
          end
        end
      end
      if (if_done || mem_done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("FAIL done_pop: unexpected done if=%b mem=%b", if_done, mem_done);
        end else begin
          ed = done_q.pop_front();
          if (if_done !== ed.is_if || (ed.is_if ? if_rdata : mem_rdata) !== ed.rdata) begin
            bad++;
            $display("FAIL done_pop: got if_done=%b if_rdata=%h mem_rdata=%h want is_if=%b rdata=%h",
                     if_done, if_rdata, mem_rdata, ed.is_if, ed.rdata);
          end
        end
      end
      if (m_ready) begin
        m_ready = 1'b0;
        wcnt    = 0;
      end else if (m_req) begin
        if (wcnt == mem_wait) begin
          m_ready = 1'b1;
          if (m_we) mem[m_addr] = m_wdata;
          else m_rdata = mem[m_addr];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
    prev_m_req = m_req;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    m_ready = 1'b0; m_rdata = '0;
    repeat (3) tick();
    total++;
    if ({m_req, m_we, if_done, mem_done, if_stall, mem_stall} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {m_req, m_we, if_done, mem_done, if_stall, mem_stall});
    end
    total++;
    if ({m_addr, m_wdata, if_rdata, mem_rdata} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got %h want 00000000", {m_addr, m_wdata, if_rdata, mem_rdata});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int   nreq = 0;
    logic got  = 1'b0;
    mem[8'h10] = 8'hA5;
    mem_wait = 2; wcnt = 0; model_on = 1'b1;
    acc_q.push_back('{8'h10, 1'b0, 8'h00});
    done_q.push_back('{1'b1, 8'hA5});
    if_req = 1'b1; if_addr = 8'h10;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (m_req) begin
        nreq++;
        total++;
        if (m_addr !== 8'h10 || m_we !== 1'b0) begin
          bad++;
          $display("FAIL fetch_hold: got addr=%h we=%b want 10 0", m_addr, m_we);
        end
      end
      total++;
      if (if_done) begin
        got = 1'b1;
        if (if_stall !== 1'b0 || if_rdata !== 8'hA5) begin
          bad++;
          $display("FAIL fetch_done: got stall=%b rdata=%h want 0 a5", if_stall, if_rdata);
        end
        if_req = 1'b0;
      end else if (if_stall !== 1'b1) begin
        bad++;
        $display("FAIL fetch_stall: got %b want 1", if_stall);
      end
    end
    total++;
    if (!got || nreq != 3) begin
      bad++;
      $display("FAIL fetch_len: got done=%b m_req_cycles=%0d want 1 3", got, nreq);
    end
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    int   md_cyc = -1;
    int   rise2  = -1;
    logic idone  = 1'b0;
    mem[8'h40] = 8'h3C; mem[8'h12] = 8'h77;
    mem_wait = 1;
    acc_q.push_back('{8'h40, 1'b0, 8'h00});
    acc_q.push_back('{8'h12, 1'b0, 8'h00});
    done_q.push_back('{1'b0, 8'h3C});
    done_q.push_back('{1'b1, 8'h77});
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
    if_req = 1'b1; if_addr = 8'h12;
    for (int i = 0; i < 60 && !idone; i++) begin
      tick();
      if (m_req_rise && md_cyc >= 0 && rise2 < 0) rise2 = cyc;
      if (mem_done) begin
        md_cyc = cyc;
        mem_req = 1'b0;
      end
      if (if_done) begin
        idone = 1'b1;
        if_req = 1'b0;
      end else begin
        total++;
        if (if_stall !== 1'b1) begin
          bad++;
          $display("FAIL simul_stall: got %b want 1", if_stall);
        end
      end
    end
    total++;
    if (!idone || md_cyc < 0 || rise2 - md_cyc != 2) begin
      bad++;
      $display("FAIL simul_gap: got if_done=%b gap=%0d want 1 2", idone, rise2 - md_cyc);
    end
    repeat (2) tick();
  endtask

  task automatic test_store();
    int ndone = 0;
    mem_wait = 1;
    mem[8'h22] = 8'h00;
    acc_q.push_back('{8'h22, 1'b1, 8'h5C});
    done_q.push_back('{1'b0, 8'h3C});
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h22; mem_wdata = 8'h5C;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_done) begin
        ndone++;
        mem_req = 1'b0;
        mem_we  = 1'b0;
      end
    end
    total++;
    if (ndone != 1 || mem_rdata !== 8'h3C || mem[8'h22] !== 8'h5C) begin
      bad++;
      $display("FAIL store: got pulses=%0d mem_rdata=%h stored=%h want 1 3c 5c", ndone, mem_rdata, mem[8'h22]);
    end
  endtask

  task automatic test_reset_mid_busy();
    model_on = 1'b0; m_ready = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h33;
    tick();
    tick();
    total++;
    if (m_req !== 1'b1 || m_addr !== 8'h33) begin
      bad++;
      $display("FAIL rstbusy_pre: got m_req=%b addr=%h want 1 33", m_req, m_addr);
    end
    rst = 1'b1;
    tick();
    total++;
    if (m_req !== 1'b0 || mem_done !== 1'b0 || m_addr !== 8'h00 || mem_rdata !== 8'h00) begin
      bad++;
      $display("FAIL rstbusy_post: got m_req=%b done=%b addr=%h rdata=%h want 0 0 00 00",
               m_req, mem_done, m_addr, mem_rdata);
    end
    rst = 1'b0; mem_req = 1'b0;
    m_ready = 1'b1; m_rdata = 8'hEE;
    tick();
    m_ready = 1'b0;
    tick();
    total++;
    if (m_req !== 1'b0 || mem_done !== 1'b0 || if_done !== 1'b0 || mem_rdata !== 8'h00) begin
      bad++;
      $display("FAIL rstbusy_late_ready: got m_req=%b done=%b/%b rdata=%h want 0 0/0 00",
               m_req, mem_done, if_done, mem_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    int d1    = -1;
    int r2    = -1;
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22;
    mem_wait = 0; wcnt = 0; model_on = 1'b1;
    acc_q.push_back('{8'h00, 1'b0, 8'h00});
    acc_q.push_back('{8'h01, 1'b0, 8'h00});
    done_q.push_back('{1'b1, 8'h11});
    done_q.push_back('{1'b1, 8'h22});
    if_req = 1'b1; if_addr = 8'h00;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      tick();
      if (m_req_rise && d1 >= 0 && r2 < 0) r2 = cyc;
      if (if_done) begin
        ndone++;
        if (ndone == 1) begin
          d1 = cyc;
          if_addr = 8'h01;
        end else begin
          if_req = 1'b0;
        end
      end
    end
    total++;
    if (ndone != 2 || r2 - d1 != 2) begin
      bad++;
      $display("FAIL b2b_gap: got dones=%0d gap=%0d want 2 2", ndone, r2 - d1);
    end
    repeat (2) tick();
    total++;
    if (acc_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got acc=%0d done=%0d left want 0 0", acc_q.size(), done_q.size());
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int   nreq = 0;
    logic got  = 1'b0;
    model_on = 1'b0; m_ready = 1'b0;
    if_req = 1'b1; if_addr = 8'h05;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (m_req) nreq++;
      if (if_done) begin
        got = 1'b1;
        if_req = 1'b0;
        total++;
        if (if_rdata !== 8'h00 || timeout_err !== 1'b1) begin
          bad++;
          $display("FAIL tmo_done: got rdata=%h err=%b want 00 1", if_rdata, timeout_err);
        end
      end
    end
    total++;
    if (!got || nreq != 16) begin
      bad++;
      $display("FAIL tmo_len: got done=%b busy_cycles=%0d want 1 16", got, nreq);
    end
    repeat (3) tick();
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: got %b want 1", timeout_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: got %b want 0", timeout_err);
    end
  endtask
`endif

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
